// File: rtl/rr_arbiter8.sv
// Eight-input round-robin arbiter: sticky request latching, fair one-hot grant
// held until acknowledged, feeding the downstream 8-to-3 encoder.
module rr_arbiter8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       grant_ack,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [7:0] pending
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [7:0] grant_n;
    logic       grant_valid_n;
    logic [7:0] pending_n;
    logic [7:0] clr;
    logic [7:0] sel;
    logic       sel_found;
    logic [2:0] sel_idx;
    logic [2:0] grant_idx;

    // First pending bit in rotated order ptr, ptr+1, ..., ptr-1 (3-bit add wraps).
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sel_idx = ptr + 3'(i);
            if (!sel_found && pending[sel_idx]) begin
                sel[sel_idx] = 1'b1;
                sel_found    = 1'b1;
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (grant[i]) begin
                grant_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        grant_n       = grant;
        grant_valid_n = grant_valid;
        clr           = '0;
        unique case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_n       = sel;
                    grant_valid_n = 1'b1;
                    state_n       = GRANT;
                end
            end
            GRANT: begin
                if (grant_ack) begin
                    clr           = grant;
                    ptr_n         = grant_idx + 3'd1;
                    grant_n       = '0;
                    grant_valid_n = 1'b0;
                    state_n       = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // A new request on the retiring edge re-arms the bit (set wins).
        pending_n = (pending & ~clr) | req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            pending     <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            grant       <= grant_n;
            grant_valid <= grant_valid_n;
            pending     <= pending_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized
// traffic compared each cycle against a behavioural round-robin model.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = '0;
    logic       grant_ack = 1'b0;
    logic [7:0] grant;
    logic       grant_valid;
    logic [7:0] pending;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_pend [8];
    int m_ptr  = 0;
    bit m_busy = 0;
    int m_gidx = 0;

    rr_arbiter8 dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant_ack   (grant_ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] m_grant();
        logic [7:0] g;
        g = '0;
        if (m_busy) g[m_gidx] = 1'b1;
        return g;
    endfunction

    function automatic logic [7:0] m_pending();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = m_pend[i];
        return p;
    endfunction

    // One rising edge of the model, from the spec's rules.
    task automatic model_edge(input logic r, input logic [7:0] q, input logic a);
        int clr_idx;
        clr_idx = -1;
        if (r) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 0;
            m_ptr  = 0;
            m_busy = 0;
            m_gidx = 0;
            return;
        end
        if (m_busy) begin
            if (a) begin
                clr_idx = m_gidx;
                m_ptr   = (m_gidx + 1) % 8;
                m_busy  = 0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                int j;
                j = (m_ptr + k) % 8;
                if (!m_busy && m_pend[j]) begin
                    m_busy = 1;
                    m_gidx = j;
                end
            end
        end
        for (int i = 0; i < 8; i++)
            m_pend[i] = (m_pend[i] && (i != clr_idx)) || q[i];
    endtask

    task automatic step(input logic r, input logic [7:0] q, input logic a);
        rst       = r;
        req       = q;
        grant_ack = a;
        @(posedge clk);
        model_edge(r, q, a);
        #1;
        rst       = 1'b0;
        req       = '0;
        grant_ack = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 8'hFF, 1'b1);
        checks++;
        if ({grant, grant_valid, pending} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%h valid=%b pending=%h, required 00/0/00", grant, grant_valid, pending);
        end
        checks++;
        if (dut.ptr !== 3'd0) begin
            errors++;
            $display("FAIL reset_ptr: got %0d required 0", dut.ptr);
        end
    endtask

    task automatic test_single();
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h01, 1'b0);
        checks++;
        if (grant_valid !== 1'b0 || pending !== 8'h01) begin
            errors++;
            $display("FAIL single_latency1: valid=%b pending=%h, required 0/01", grant_valid, pending);
        end
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (grant !== 8'h01 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%h valid=%b, required 01/1", grant, grant_valid);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || pending !== 8'h00 || dut.ptr !== 3'd1) begin
            errors++;
            $display("FAIL single_ack: grant=%h valid=%b pending=%h ptr=%0d, required 00/0/00/1",
                     grant, grant_valid, pending, dut.ptr);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp = 8'h01 << i;
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (grant !== exp || grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep_grant%0d: grant=%h valid=%b, required %h/1", i, grant, grant_valid, exp);
            end
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (grant_valid !== 1'b0) begin
                errors++;
                $display("FAIL sweep_gap%0d: valid=%b, required 0", i, grant_valid);
            end
        end
        checks++;
        if (pending !== 8'h00 || dut.ptr !== 3'd0) begin
            errors++;
            $display("FAIL sweep_end: pending=%h ptr=%0d, required 00/0", pending, dut.ptr);
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h04, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (dut.ptr !== 3'd3) begin
            errors++;
            $display("FAIL wrap_setup_ptr: got %0d required 3", dut.ptr);
        end
        step(1'b0, 8'h42, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (grant !== 8'h40) begin
            errors++;
            $display("FAIL wrap_first: grant=%h required 40", grant);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (grant !== 8'h02) begin
            errors++;
            $display("FAIL wrap_second: grant=%h required 02", grant);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (dut.ptr !== 3'd2 || pending !== 8'h00) begin
            errors++;
            $display("FAIL wrap_end: ptr=%0d pending=%h, required 2/00", dut.ptr, pending);
        end
    endtask

    task automatic test_stall();
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h04, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i == 4) ? 8'h81 : 8'h00, 1'b0);
            checks++;
            if (grant !== 8'h04 || grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: grant=%h valid=%b, required 04/1", i, grant, grant_valid);
            end
        end
        checks++;
        if (pending !== 8'h85) begin
            errors++;
            $display("FAIL stall_pending: got %h required 85", pending);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (grant !== 8'h80) begin
            errors++;
            $display("FAIL stall_next: grant=%h required 80", grant);
        end
    endtask

    task automatic test_set_wins();
        logic [7:0] order [3];
        order[0] = 8'h10;
        order[1] = 8'h20;
        order[2] = 8'h04;
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h34, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (grant !== 8'h04) begin
            errors++;
            $display("FAIL setwins_first: grant=%h required 04", grant);
        end
        step(1'b0, 8'h04, 1'b1);
        checks++;
        if (pending !== 8'h34) begin
            errors++;
            $display("FAIL setwins_pending: got %h required 34", pending);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0);
            checks++;
            if (grant !== order[i]) begin
                errors++;
                $display("FAIL setwins_order%0d: grant=%h required %h", i, grant, order[i]);
            end
            step(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_reset_mid_grant();
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (grant_valid !== 1'b1 || pending !== 8'h3C) begin
            errors++;
            $display("FAIL midrst_setup: valid=%b pending=%h, required 1/3C", grant_valid, pending);
        end
        step(1'b1, 8'h00, 1'b0);
        checks++;
        if ({grant, grant_valid, pending} !== 17'd0 || dut.ptr !== 3'd0) begin
            errors++;
            $display("FAIL midrst_clear: grant=%h valid=%b pending=%h ptr=%0d, required all 0",
                     grant, grant_valid, pending, dut.ptr);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if ({grant, grant_valid, pending} !== 17'd0 || dut.ptr !== 3'd0) begin
            errors++;
            $display("FAIL midrst_ack_ignored: grant=%h valid=%b pending=%h ptr=%0d, required all 0",
                     grant, grant_valid, pending, dut.ptr);
        end
    endtask

    task automatic test_random();
        logic [7:0] q;
        logic       a;
        logic       r;
        step(1'b1, 8'h00, 1'b0);
        for (int n = 0; n < 600; n++) begin
            q = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            a = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 99) == 0);
            step(r, q, a);
            checks++;
            if (grant !== m_grant() || grant_valid !== m_busy || pending !== m_pending()
                || dut.ptr !== 3'(m_ptr)) begin
                errors++;
                $display("FAIL random_cycle%0d: grant=%h valid=%b pending=%h ptr=%0d, required %h/%b/%h/%0d",
                         n, grant, grant_valid, pending, dut.ptr, m_grant(), m_busy, m_pending(), m_ptr);
            end
            checks++;
            if (!$onehot0(grant) || ((grant != 8'h00) !== grant_valid)) begin
                errors++;
                $display("FAIL random_onehot%0d: grant=%h valid=%b, required onehot0 and nonzero iff valid",
                         n, grant, grant_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_wrap();
        test_stall();
        test_set_wins();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
